// File: rtl/sort4_controller.sv
// sort4_controller
//   Loads four WIDTH-bit operands and sorts them into ascending order.
//   The sort is a six-step bubble network on the registers q0..q3. A single
//   shared less-than comparator does one compare per SORT cycle. Equal values
//   are never exchanged, so the sort is stable.
//
// Ports
//   clk          : single clock; all state updates on the rising edge
//   reset        : synchronous, active-high; clears all state to IDLE/zero
//   start        : load-and-sort request, honoured only in IDLE
//   signed_mode  : 1 = two's-complement compare, 0 = unsigned; sampled with start
//   d0..d3       : operands, sampled with start
//   q0..q3       : working/result registers (q0 smallest after completion)
//   busy         : high in SORT and DONE
//   done         : one-cycle completion pulse (the DONE state)
//   swap_count   : number of exchanges in the current or last sort (max 6)
module sort4_controller #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swap_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             mode_q, mode_d;
  logic [2:0]       swap_count_q, swap_count_d;
  logic [WIDTH-1:0] q_q [4];
  logic [WIDTH-1:0] q_d [4];

  // Pair selection for the shared comparator: steps 0..5 visit the lower
  // index 0,1,2,0,1,0; the upper index is always the next register.
  logic [1:0]       lo_idx;
  logic [1:0]       hi_idx;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;
  logic             hi_lt_lo;

  always_comb begin
    case (step_q)
      3'd1, 3'd4: lo_idx = 2'd1;
      3'd2:       lo_idx = 2'd2;
      default:    lo_idx = 2'd0;
    endcase
    hi_idx = lo_idx + 2'd1;
    lo_val = q_q[lo_idx];
    hi_val = q_q[hi_idx];
    // Strict less-than: equal elements stay put, keeping the sort stable.
    if (mode_q) begin
      hi_lt_lo = $signed(hi_val) < $signed(lo_val);
    end else begin
      hi_lt_lo = hi_val < lo_val;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mode_d       = mode_q;
    swap_count_d = swap_count_q;
    q_d          = q_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d[0]       = d0;
          q_d[1]       = d1;
          q_d[2]       = d2;
          q_d[3]       = d3;
          mode_d       = signed_mode;
          swap_count_d = 3'd0;
          step_d       = 3'd0;
          state_d      = ST_SORT;
        end
      end
      ST_SORT: begin
        if (hi_lt_lo) begin
          q_d[lo_idx]  = hi_val;
          q_d[hi_idx]  = lo_val;
          // At most six compares per sort, so this cannot pass 6.
          swap_count_d = swap_count_q + 3'd1;
        end
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= 3'd0;
      mode_q       <= 1'b0;
      swap_count_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      mode_q       <= mode_d;
      swap_count_q <= swap_count_d;
      q_q          <= q_d;
    end
  end

  assign q0         = q_q[0];
  assign q1         = q_q[1];
  assign q2         = q_q[2];
  assign q3         = q_q[3];
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort4_controller.sv
// Scoreboard bench for sort4_controller: a stimulus process issues sorts and
// pushes the expected result; a monitor pops and compares on each done pulse.
module tb_sort4_controller;
  localparam int W = 6;

  typedef logic [3:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t       v;
    logic [2:0] swaps;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] d0, d1, d2, d3;
  logic [W-1:0] q0, q1, q2, q3;
  logic         busy, done;
  logic [2:0]   swap_count;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  sort4_controller #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .busy(busy), .done(done), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Numeric value of an element under the chosen interpretation.
  function automatic int key(input logic [W-1:0] x, input bit m);
    if (m && x[W-1]) return int'(x) - (1 << W);
    return int'(x);
  endfunction

  // Reference: stable ascending order; the number of exchanges a
  // compare-exchange network of adjacent swaps makes equals the inversion count.
  function automatic exp_t model(input vec_t dv, input bit m);
    exp_t r;
    int   vals[4];
    int   inv = 0;
    int   idx[$];
    for (int i = 0; i < 4; i++) vals[i] = key(dv[i], m);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (vals[j] < vals[i]) inv++;
    // Stable order: output each element after all strictly-smaller ones and
    // after equal ones with a lower original index.
    for (int i = 0; i < 4; i++) begin
      int rank = 0;
      for (int j = 0; j < 4; j++)
        if (vals[j] < vals[i] || (vals[j] == vals[i] && j < i)) rank++;
      r.v[rank] = dv[i];
    end
    r.swaps = 3'(inv);
    return r;
  endfunction

  function automatic vec_t pack4(input int a, input int b, input int c, input int e);
    vec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c); v[3] = W'(e);
    return v;
  endfunction

  // Monitor: compare on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_q", {8'd0, q3, q2, q1, q0}, {8'd0, e.v[3], e.v[2], e.v[1], e.v[0]});
        chk("swap_count", 32'(swap_count), 32'(e.swaps));
        $display("sort result q=(%0h,%0h,%0h,%0h) swaps=%0d", q0, q1, q2, q3, swap_count);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge where
  // done is visible.
  task automatic run_sort(input vec_t dv, input bit m, input bit noise);
    int cnt;
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    signed_mode = m;
    start = 1'b1;
    last_exp = model(dv, m);
    exp_q.push_back(last_exp);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 20) begin
      chk("busy_in_sort", 32'(busy), 32'd1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("latency", 32'(cnt), 32'd7);
    chk("busy_in_done", 32'(busy), 32'd1);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk(name, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {5'd0, swap_count, q3, q2, q1, q0}, 32'd0);
    chk("reset_flags", {30'd0, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_sort(pack4(5, 3, 9, 1), 1'b0, 1'b0);          check_idle("idle_after_done");
    run_sort(pack4('h01, 'h3F, 'h20, 'h1F), 1'b1, 1'b0); check_idle("idle_after_done");
    run_sort(pack4('h01, 'h3F, 'h20, 'h1F), 1'b0, 1'b0); check_idle("idle_after_done");
    run_sort(pack4(1, 2, 3, 4), 1'b0, 1'b0);          check_idle("idle_after_done");
    run_sort(pack4(4, 3, 2, 1), 1'b0, 1'b0);          check_idle("idle_after_done");
    run_sort(pack4(7, 7, 7, 7), 1'b1, 1'b0);          check_idle("idle_after_done");
    // Start and input changes while busy are ignored; restart in first IDLE cycle.
    run_sort(pack4(9, 2, 8, 1), 1'b0, 1'b1);
    @(negedge clk);
    run_sort(pack4('h30, 'h10, 'h3F, 'h00), 1'b1, 1'b1);
    check_idle("idle_after_done");

    // Hold in IDLE with changing inputs.
    for (int i = 0; i < 20; i++) begin
      d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_q", {8'd0, q3, q2, q1, q0},
          {8'd0, last_exp.v[3], last_exp.v[2], last_exp.v[1], last_exp.v[0]});
      chk("hold_swaps", 32'(swap_count), 32'(last_exp.swaps));
    end

    // Randomized sorts, some with busy-time noise.
    for (int i = 0; i < 30; i++) begin
      vec_t rv;
      for (int k = 0; k < 4; k++) rv[k] = W'($urandom);
      if (i % 5 == 0) rv[2] = rv[0];
      run_sort(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_idle("idle_after_done");
    end

    // Reset during SORT step 3, with start also high: abandoned, no done.
    d0 = W'(4); d1 = W'(3); d2 = W'(2); d3 = W'(1);
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("midsort_reset_outputs", {5'd0, swap_count, q3, q2, q1, q0}, 32'd0);
    chk("midsort_reset_flags", {30'd0, busy, done}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", 32'(done), 32'd0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort4_controller.md
SORT4_CONTROLLER -- requirements
Module: sort4_controller

Interface
REQ-001 The module SHALL have parameter WIDTH, default 6, setting the element width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit, a request to load and sort, honoured only in IDLE.
REQ-005 The module SHALL have port signed_mode, input, 1 bit: 1 selects a two's-complement comparison, 0 selects an unsigned comparison; it is sampled with start.
REQ-006 The module SHALL have ports d0, d1, d2 and d3, each input, WIDTH bits, the operands sampled with start.
REQ-007 The module SHALL have ports q0, q1, q2 and q3, each output, WIDTH bits, the working and result registers; after completion they hold ascending order with q0 the smallest.
REQ-008 The module SHALL have port busy, output, 1 bit, high in the SORT and DONE states.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 The module SHALL have port swap_count, output, 3 bits, the number of swaps performed in the current or last sort.

Function
REQ-011 The FSM SHALL have states IDLE, SORT and DONE.
REQ-012 In IDLE with start=1: on the edge, q0..q3 SHALL load d0..d3, the mode register SHALL load signed_mode, swap_count SHALL become 0, step SHALL become 0 and the state SHALL become SORT.
REQ-013 A single shared less-than comparator SHALL be used, and it SHALL perform exactly one compare per SORT cycle.
REQ-014 Steps 0..5 SHALL compare the pairs (q0,q1), (q1,q2), (q2,q3), (q0,q1), (q1,q2), (q0,q1) in that order.
REQ-015 For each pair (lo,hi), if hi < lo under the latched mode, the two registers SHALL exchange on the edge and swap_count SHALL increment; otherwise no change SHALL occur.
REQ-016 Equal values SHALL NOT swap, so the sort is stable.
REQ-017 The signed compare SHALL treat the MSB as the sign bit: with WIDTH=6, 6'h3F is -1 and 6'h20 is -32.
REQ-018 After the step-5 edge the state SHALL become DONE; DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-019 Latency SHALL be: start sampled at edge E, SORT occupies the cycles after edges E..E+5, and done=1 in the cycle after edge E+6.
REQ-020 Total occupancy SHALL be 7 cycles with busy=1, and a new start SHALL be accepted in the first IDLE cycle after DONE.
REQ-021 start while busy=1 SHALL be ignored; d0..d3 and signed_mode changes during SORT SHALL have no effect.
REQ-022 In IDLE, q0..q3, swap_count and the mode register SHALL hold their values indefinitely.
REQ-023 swap_count SHALL never exceed 6, and no wrap SHALL occur.
REQ-024 The mode register SHALL remain constant from load until the next accepted start.

Reset
REQ-025 With reset=1 at an edge, the state SHALL become IDLE and q0..q3, swap_count, step, mode, busy and done SHALL all become 0.
REQ-026 Reset SHALL take priority over start and over any SORT or DONE activity.
REQ-027 Reset mid-sort SHALL abandon the operation, and no done pulse SHALL follow.
REQ-028 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-029 Unsigned: d=(5,3,9,1), signed_mode=0, start -> after 7 cycles q=(1,3,5,9), done pulse of exactly 1 cycle, swap_count=4.
REQ-030 Signed: d=(6'h01,6'h3F,6'h20,6'h1F), signed_mode=1 -> q=(6'h20,6'h3F,6'h01,6'h1F), i.e. (-32,-1,1,31); the same data with signed_mode=0 -> q=(6'h01,6'h1F,6'h20,6'h3F).
REQ-031 Already sorted (1,2,3,4) -> swap_count=0; reverse order (4,3,2,1) -> q=(1,2,3,4) and swap_count=6; all equal (7,7,7,7) -> swap_count=0.
REQ-032 Start during busy: a second start with different d at cycles 2..6 is ignored, the first result completes, and a start on the first IDLE cycle after DONE is accepted.
REQ-033 Reset in SORT step 3 -> next cycle all outputs are 0, state IDLE, and no done pulse occurs in the following 10 cycles.
REQ-034 Hold: after completion, toggling d0..d3 with start=0 for 20 cycles leaves q0..q3 and swap_count unchanged.
